// File: rtl/sabals_alu.sv
// -----------------------------------------------------------------------------
// sabals_alu -- single-cycle 8-bit ALU with a registered 16-bit result.
//
// The ALU samples in1/in2/select on each rising clock edge and presents the
// result on out from that edge until the next one. Narrow results are
// zero-extended to 16 bits.
//
// Ports:
//   clk     in   1   clock, all state updates on the rising edge
//   rst     in   1   synchronous active-high reset, clears out to 0
//   in1     in   8   operand A (unsigned)
//   in2     in   8   operand B (unsigned)
//   select  in   4   operation code
//   out     out 16   registered result (unsigned)
//
// Configuration macro:
//   SABALS_ALU_DIV_EN  defined   -> opcodes 0100 (divide) and 0101 (modulo)
//                                   are implemented
//                      undefined -> no divider is built; both opcodes give 0
// -----------------------------------------------------------------------------
module sabals_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [3:0]  select,
  output logic [15:0] out
);

  logic [15:0] out_d;
  logic [15:0] out_q;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [8:0]  sum9;
  logic [15:0] div_res;
  logic [15:0] mod_res;

  // Halving the 9-bit sum keeps the carry, so 255+255 averages to 255.
  function automatic logic [15:0] avg_floor(input logic [8:0] s);
    avg_floor = {8'h00, s[8:1]};
  endfunction

  assign a16  = {8'h00, in1};
  assign b16  = {8'h00, in2};
  assign sum9 = {1'b0, in1} + {1'b0, in2};

`ifdef SABALS_ALU_DIV_EN
  // Division by zero returns all-ones for the quotient and the dividend
  // for the remainder, so no X or tool-defined value ever reaches out.
  always_comb begin
    div_res = 16'hFFFF;
    mod_res = a16;
    if (in2 != 8'h00) begin
      div_res = {8'h00, in1 / in2};
      mod_res = {8'h00, in1 % in2};
    end
  end
`else
  assign div_res = 16'h0000;
  assign mod_res = 16'h0000;
`endif

  always_comb begin
    out_d = 16'h0000;
    case (select)
      4'b0000: out_d = a16;
      4'b0001: out_d = b16;
      4'b0010: out_d = {7'h00, sum9};
      4'b0011: out_d = a16 - b16;
      4'b0100: out_d = div_res;
      4'b0101: out_d = mod_res;
      4'b0110: out_d = a16 << in2[3:0];
      4'b0111: out_d = a16 >> in2[3:0];
      4'b1000: out_d = {15'h0000, (in1 > in2)};
      4'b1001: out_d = {15'h0000, (in1 == in2)};
      4'b1010: out_d = a16 * b16;
      4'b1011: out_d = {8'h00, in1 & in2};
      4'b1100: out_d = {8'h00, in1 | in2};
      4'b1101: out_d = {8'h00, in1 ^ in2};
      4'b1110: out_d = {in1, in2};
      4'b1111: out_d = avg_floor(sum9);
      default: out_d = 16'h0000;
    endcase
  end

  // Result register: reset overrides any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sabals_alu.sv
// -----------------------------------------------------------------------------
// tb_sabals_alu -- self-checking bench for sabals_alu.
// Inputs are driven on the falling edge; expected results are queued when
// driven and popped/compared on the following falling edge, after the DUT
// has registered them on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_sabals_alu;

  logic        clk;
  logic        rst;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [3:0]  select;
  logic [15:0] out;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  sabals_alu dut (
    .clk    (clk),
    .rst    (rst),
    .in1    (in1),
    .in2    (in2),
    .select (select),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

`ifdef SABALS_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Reference model written with integer arithmetic, independent of the RTL.
  function automatic logic [15:0] ref_alu(input int a, input int b, input int s);
    int r;
    r = 0;
    case (s)
      0:  r = a;
      1:  r = b;
      2:  r = a + b;
      3:  r = (a - b + 65536) % 65536;
      4:  r = !DIV_EN ? 0 : (b == 0 ? 65535 : a / b);
      5:  r = !DIV_EN ? 0 : (b == 0 ? a : a % b);
      6:  r = (a * (1 << (b % 16))) % 65536;
      7:  r = a / (1 << (b % 16));
      8:  r = (a > b) ? 1 : 0;
      9:  r = (a == b) ? 1 : 0;
      10: r = a * b;
      11: r = a & b;
      12: r = a | b;
      13: r = a ^ b;
      14: r = a * 256 + b;
      15: r = (a + b) / 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic check_pop();
    logic [15:0] e;
    string       n;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", out);
      return;
    end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    if (out !== e) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, out, e);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge after checking.
  task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] s, input logic [15:0] e, input string n);
    rst    = r;
    in1    = a;
    in2    = b;
    select = s;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  logic [15:0] sweep_exp [16];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    in1    = 8'd10;
    in2    = 8'd5;
    select = 4'b0010;

    sweep_exp = '{16'd10, 16'd5, 16'd15, 16'd5,
                  DIV_EN ? 16'd2 : 16'd0, 16'd0,
                  16'd320, 16'd0, 16'd1, 16'd0, 16'd50, 16'd0,
                  16'd15, 16'd15, 16'h0A05, 16'd7};

    // Reset, release, and the opcode sweep with 10/5.
    vecs.push_back('{1'b1, 8'd10, 8'd5, 4'b0010, 16'd0, "reset_edge1"});
    vecs.push_back('{1'b1, 8'd10, 8'd5, 4'b0010, 16'd0, "reset_edge2"});
    vecs.push_back('{1'b0, 8'd10, 8'd5, 4'b0010, 16'd15, "reset_release"});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 8'd10, 8'd5, 4'(i), sweep_exp[i], $sformatf("sweep_op%0d", i)});

    // Boundary cases.
    vecs.push_back('{1'b0, 8'd5,   8'd10,  4'b0011, 16'hFFFB, "sub_wrap"});
    vecs.push_back('{1'b0, 8'd5,   8'd10,  4'b1000, 16'h0000, "gt_false"});
    vecs.push_back('{1'b0, 8'd7,   8'd7,   4'b1001, 16'h0001, "eq_true"});
    vecs.push_back('{1'b0, 8'd7,   8'd7,   4'b1000, 16'h0000, "gt_equal"});
    vecs.push_back('{1'b0, 8'd200, 8'd0,   4'b0100, DIV_EN ? 16'hFFFF : 16'h0000, "div_by_zero"});
    vecs.push_back('{1'b0, 8'd200, 8'd0,   4'b0101, DIV_EN ? 16'd200 : 16'h0000, "mod_by_zero"});
    vecs.push_back('{1'b0, 8'd200, 8'd7,   4'b0101, DIV_EN ? 16'd4 : 16'h0000, "mod_nonzero"});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 4'b0010, 16'd510, "add_carry"});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 4'b1010, 16'hFE01, "mul_max"});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 4'b1111, 16'd255, "avg_max"});
    vecs.push_back('{1'b0, 8'd255, 8'h1F,  4'b0110, 16'h8000, "shl_15"});
    vecs.push_back('{1'b0, 8'hB4,  8'hF3,  4'b0111, 16'h0016, "shr_hi_ignored"});
    vecs.push_back('{1'b1, 8'd255, 8'd255, 4'b1010, 16'h0000, "reset_priority"});

    @(negedge clk);
    foreach (vecs[i])
      apply(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].name);

    // Operands/opcode change mid-cycle: out must hold until the next edge.
    rst = 1'b0; in1 = 8'd3; in2 = 8'd4; select = 4'b0010;
    exp_q.push_back(16'd7); name_q.push_back("hold_before_change");
    @(posedge clk);
    #2;
    in1 = 8'd100; select = 4'b1010;
    #1;
    checks++;
    if (out !== 16'd7) begin
      errors++;
      $display("FAIL hold_immediate: got %h, expected %h", out, 16'd7);
    end
    @(negedge clk);
    check_pop();
    exp_q.push_back(16'd400); name_q.push_back("after_change");
    @(posedge clk);
    @(negedge clk);
    check_pop();

    // Reset mid-sequence discards the pending result, then recovers at once.
    apply(1'b0, 8'd12, 8'd3, 4'b1010, 16'd36, "pre_reset_op");
    apply(1'b1, 8'd12, 8'd3, 4'b1110, 16'd0,  "mid_reset");
    apply(1'b0, 8'd12, 8'd3, 4'b1110, 16'h0C03, "post_reset_op");

    // Random vectors against the integer model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      logic [3:0] s;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = 4'($urandom_range(0, 15));
      apply(1'b0, a, b, s, ref_alu(int'(a), int'(b), int'(s)), $sformatf("rand%0d_op%0d", i, s));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
